// File: rtl/fb_bank_ctrl.sv
// Ping-pong framebuffer controller: writes the incoming pixel stream into the
// bank the display is not reading, and swaps banks on a display frame pulse.
module fb_bank_ctrl #(
  parameter int p_fb_width   = 160,
  parameter int p_fb_height  = 120,
  parameter int p_data_width = 8,
  localparam int c_addrw     = $clog2(p_fb_width * p_fb_height)
) (
  input  logic                    i_clk_pixel,
  input  logic                    i_rst,
  input  logic                    i_frame,
  input  logic                    i_wr_valid,
  input  logic                    i_wr_sof,
  input  logic [p_data_width-1:0] i_wr_data,
  output logic                    o_wr_ready,
  output logic                    o_wr_en,
  output logic [c_addrw:0]        o_wr_addr,
  output logic [p_data_width-1:0] o_wr_data,
  output logic                    o_rd_bank,
  output logic                    o_swap,
  output logic                    o_sync_err,
  output logic [7:0]              o_frame_cnt
);

  localparam logic [c_addrw-1:0] c_last = c_addrw'(p_fb_width * p_fb_height - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [c_addrw-1:0]      count_q, count_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [c_addrw:0]        wr_addr_q, wr_addr_d;
  logic [p_data_width-1:0] wr_data_q, wr_data_d;
  logic                    swap_q, swap_d;
  logic                    sync_err_q, sync_err_d;

  logic                    accept;
  logic                    do_write;
  logic [c_addrw-1:0]      wr_idx;

  // Ready is held low during reset so no beat is taken before state is known.
  assign o_wr_ready = ~i_rst & (state_q != DONE);
  assign accept     = i_wr_valid & o_wr_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    swap_d      = 1'b0;
    sync_err_d  = 1'b0;
    do_write    = 1'b0;
    wr_idx      = '0;

    unique case (state_q)
      IDLE: begin
        if (accept && i_wr_sof) begin
          do_write = 1'b1;
          count_d  = c_addrw'(1);
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          do_write = 1'b1;
          // A fresh SOF always restarts the frame, even on the final pixel.
          if (i_wr_sof) begin
            count_d    = c_addrw'(1);
            sync_err_d = 1'b1;
          end else begin
            wr_idx = count_q;
            if (count_q == c_last) begin
              count_d = '0;
              state_d = DONE;
            end else begin
              count_d = count_q + c_addrw'(1);
            end
          end
        end
      end
      DONE: begin
        if (i_frame) begin
          rd_bank_d   = ~rd_bank_q;
          frame_cnt_d = frame_cnt_q + 8'd1;
          swap_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {~rd_bank_q, wr_idx};
      wr_data_d = i_wr_data;
    end
  end

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_bank_q   <= 1'b0;
      frame_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      swap_q      <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_bank_q   <= rd_bank_d;
      frame_cnt_q <= frame_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      swap_q      <= swap_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_rd_bank   = rd_bank_q;
  assign o_swap      = swap_q;
  assign o_sync_err  = sync_err_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule
